instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time instruction loader sitting directly upstream of `mips_single_cycle`. Accepts a byte stream over a valid/ready handshake, packs it into 19-bit instruction words, and writes them sequentially into instruction memory from address 0. It holds the processor in reset until a complete, checksum-verified image has been written, then releases it.

## Interface
- `ADDR_W`, 12: instruction-memory address width; depth is 2^ADDR_W words.
- `INSTR_W`, 19: instruction word width; fixed to the core's instruction width.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load session.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge where `in_valid && in_ready`.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  INSTR_W  write data.
- `core_hold`  out  1  high holds the processor in reset.
- `busy`  out  1  a session is in progress.
- `done`  out  1  image loaded and verified; sticky.
- `err`  out  1  session failed; sticky.

## Operation
- Stream format: `LEN_HI`, `LEN_LO` (word count N, 16-bit, big-endian), then N×3 payload bytes (each word big-endian: byte0[2:0] gives bits 18:16, byte0[7:3] ignored; byte1 gives 15:8; byte2 gives 7:0), then one checksum byte.
- Checksum is the XOR of all 3N payload bytes. The length bytes are excluded.
- States: IDLE, LEN_HI, LEN_LO, B0, B1, B2, WR, CHK, DONE, ERR.
  - IDLE/DONE/ERR go to LEN_HI on `start`. This clears `done` and `err`, and resets the address and checksum to 0.
  - LEN_HI → LEN_LO → B0 on transfer. If N==0 or N>2^ADDR_W, go to ERR instead of B0.
  - B0 → B1 → B2 on transfer. B2 → WR on transfer.
  - WR lasts one cycle. It goes to B0 if words remain, else to CHK.
  - CHK → DONE on transfer if the byte equals the running XOR, else → ERR.
- `start` is ignored in every state other than IDLE, DONE and ERR.
- `in_ready` is 1 in LEN_HI, LEN_LO, B0, B1, B2 and CHK. It is 0 in IDLE, WR, DONE and ERR, so bytes presented in those states are not consumed.
- `imem_we` is 1 only in WR. In that cycle `imem_addr` holds the current word index and `imem_wdata` holds the packed word. The address increments on the edge leaving WR. For N=2^ADDR_W the address wraps to 0 after the last write; this is harmless because the next state is CHK.
- `core_hold` is 0 only in DONE. `busy` is 1 in LEN_HI through CHK.
- `done` is high in DONE. `err` is high in ERR.
- Reset mid-session: all state is discarded and outputs return to reset values. Memory contents already written are left unchanged.
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=1, `busy`=0, `done`=0, `err`=0. State is IDLE.

## Timing
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Byte2 of a word is accepted on edge k. `imem_we` is high from edge k to edge k+1, and memory captures the word on edge k+1.
- Minimum session length is 2 + 4N + 1 cycles of accepted bytes/writes after the `start` edge.
- A passing checksum is accepted on edge k. `done`=1 and `core_hold`=0 from edge k onward, so the processor's first cycle out of reset follows edge k.
- A bad length or bad checksum takes effect on its accepting edge: `err`=1 from that edge, and `core_hold` stays 1.

## Structure
- Package `instr_loader_pkg`:
  - state enum;
  - `INSTR_W`=19;
  - `BYTES_PER_WORD`=3;
  - length field width 16.
- One natural sub-module: `instr_word_packer`. It is a byte shift register that accumulates byte0–byte2, masks byte0[7:3], and keeps the running XOR. It has a clear input driven on `start`.
- The FSM, address counter and word counter live in the top.

## Test plan
- Load N=2, words 0x7FFFF and 0x00001, correct checksum → writes (0, 0x7FFFF) then (1, 0x00001). `done`=1, `core_hold`=0, `err`=0.
- Same stream with checksum XOR 0x01 → both writes occur. `err`=1, `done`=0, `core_hold` stays 1.
- N=0, and separately N=4097 with ADDR_W=12 → ERR immediately after LEN_LO, no `imem_we` pulse.
- Randomly deassert `in_valid` and hold it high during WR → no byte lost or duplicated, and exactly one write per word.
- Assert `rst` low during B1 of word 3 → outputs at reset values immediately. A fresh `start` reloads from address 0.
- Pulse `start` mid-session (ignored), and again after DONE → the second pulse restarts the session: `core_hold`=1, `done`=0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Stream framing: 16-bit word count, 3 bytes per 19-bit word, one XOR checksum byte.
package instr_loader_pkg;

  localparam int INSTR_W        = 19;
  localparam int BYTES_PER_WORD = 3;
  localparam int LEN_W          = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_B0     = 4'd3,
    S_B1     = 4'd4,
    S_B2     = 4'd5,
    S_WR     = 4'd6,
    S_CHK    = 4'd7,
    S_DONE   = 4'd8,
    S_ERR    = 4'd9
  } state_t;

endpackage

// File: rtl/instr_word_packer.sv
// Byte shift register that assembles a 19-bit word from three payload bytes and
// keeps the running XOR of every payload byte since the last clear.
module instr_word_packer
  import instr_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [7:0]         i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic [7:0]         o_xor
);

  logic [INSTR_W-1:0] r_word;
  logic [7:0]         r_xor;

  // Three 8-bit shifts into a 19-bit register leave only byte0[2:0] on top,
  // which discards byte0[7:3] without a separate mask stage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_word <= '0;
      r_xor  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_xor  <= '0;
    end else if (i_push) begin
      r_word <= {r_word[INSTR_W-9:0], i_byte};
      r_xor  <= r_xor ^ i_byte;
    end
  end

  assign o_word = r_word;
  assign o_xor  = r_xor;

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction memory from
// address 0 and holds the core in reset until the whole image is verified.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [7:0]         i_in_data,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic               o_imem_we,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_core_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [LEN_W:0] ONE_N = 1;
  localparam logic [LEN_W:0] MAX_N = ONE_N << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_len_hi;
  logic [LEN_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic              w_xfer;
  logic              w_idle_like;
  logic              w_clr;
  logic              w_push;
  logic [7:0]        w_xor;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_clr       = i_start && w_idle_like;
  assign w_xfer      = i_in_valid && o_in_ready;
  assign w_push      = w_xfer && ((r_state == S_B0) || (r_state == S_B1) || (r_state == S_B2));
  assign w_len       = {r_len_hi, i_in_data};
  assign w_len_bad   = (w_len == '0) || ({1'b0, w_len} > MAX_N);

  instr_word_packer u_packer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_push (w_push),
    .i_byte (i_in_data),
    .o_word (o_imem_wdata),
    .o_xor  (w_xor)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = w_len_bad ? S_ERR : S_B0;
      S_B0:     if (w_xfer) w_next = S_B1;
      S_B1:     if (w_xfer) w_next = S_B2;
      S_B2:     if (w_xfer) w_next = S_WR;
      S_WR:     w_next = (r_remain == LEN_W'(1)) ? S_CHK : S_B0;
      S_CHK:    if (w_xfer) w_next = (i_in_data == w_xor) ? S_DONE : S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_len_hi <= '0;
      r_remain <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_addr <= '0;
      end
      if (w_xfer && (r_state == S_LEN_HI)) begin
        r_len_hi <= i_in_data;
      end
      if (w_xfer && (r_state == S_LEN_LO)) begin
        r_remain <= w_len;
      end
      // Wrap to 0 after a full-depth image is harmless: CHK follows.
      if (r_state == S_WR) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  assign o_in_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_B0) ||
                       (r_state == S_B1) || (r_state == S_B2) || (r_state == S_CHK);
  assign o_imem_we   = (r_state == S_WR);
  assign o_imem_addr = r_addr;
  assign o_busy      = o_in_ready || (r_state == S_WR);
  assign o_core_hold = (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: streams are built per test, an abstract model
// derives the expected writes and outcome, and a negedge monitor checks every write.
module tb_instr_loader;

  typedef struct {
    logic [11:0] a;
    logic [18:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [18:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  stream [$];
  wr_t         exp_q [$];
  logic [18:0] mem [0:4095];
  int          checks;
  int          errors;

  bit          m_good;
  int          m_bytes;
  logic [7:0]  m_xor;

  instr_loader #(.ADDR_W(12)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_core_hold  (core_hold),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: derive the write list and outcome from the stream's own framing rules.
  task automatic model();
    int n;
    logic [7:0] b0, b1, b2;
    exp_q.delete();
    n = {stream[0], stream[1]};
    m_xor = 8'h00;
    if (n == 0 || n > 4096) begin
      m_good  = 1'b0;
      m_bytes = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        b0 = stream[2 + 3*i];
        b1 = stream[3 + 3*i];
        b2 = stream[4 + 3*i];
        exp_q.push_back('{a: 12'(i), d: {b0[2:0], b1, b2}});
        m_xor = m_xor ^ b0 ^ b1 ^ b2;
      end
      m_bytes = 3*n + 3;
      m_good  = (stream[3*n + 2] == m_xor);
    end
  endtask

  task automatic make_stream(input int n, input bit rnd, input logic [7:0] chk_flip);
    logic [15:0] len;
    logic [18:0] w;
    logic [7:0]  junk, b0, x;
    len = 16'(n);
    stream.delete();
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w    = rnd ? 19'($urandom) : 19'(i * 37 + 5);
      junk = 8'($urandom);
      b0   = {junk[7:3], w[18:16]};
      stream.push_back(b0);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      x = x ^ b0 ^ w[15:8] ^ w[7:0];
    end
    if (n > 0 && n <= 4096) stream.push_back(x ^ chk_flip);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_hold", 32'(core_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
  endtask

  // Feed the stream from negedge to negedge; abort_at>=0 stops after that many bytes.
  task automatic send(input int gap_pct, input int abort_at, input int start_at);
    int  idx;
    int  cycles;
    bit  xfer;
    bit  started;
    idx = 0;
    cycles = 0;
    started = 1'b0;
    while (idx < stream.size() && cycles < 40000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      in_data  = stream[idx];
      in_valid = ($urandom_range(0, 99) >= gap_pct) || imem_we;
      start    = (idx == start_at) && !started;
      if (start) started = 1'b1;
      xfer = in_valid && in_ready;
      @(posedge clk);
      if (xfer) idx++;
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
    if (cycles >= 40000) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: consumed %0d bytes, expected %0d", idx, m_bytes);
    end
    if (abort_at < 0) begin
      check("bytes_consumed", 32'(idx), 32'(m_bytes));
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("end_ready", 32'(in_ready), 32'd0);
      check("end_done", 32'(done), 32'(m_good));
      check("end_err", 32'(err), 32'(!m_good));
      check("end_hold", 32'(core_hold), 32'(!m_good));
      check("end_busy", 32'(busy), 32'd0);
      check("writes_left", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Monitor: every write strobe must match the next expected (address, word).
  always @(negedge clk) begin
    if (rst) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", 32'(imem_addr), 32'(exp_q[0].a));
          check("wr_data", 32'(imem_wdata), 32'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
        mem[imem_addr] = imem_wdata;
      end
      if (done || err) check("idle_not_busy", 32'(busy), 32'd0);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Two words 0x7FFFF, 0x00001 with good checksum (XOR = 0x06).
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h02);
    stream.push_back(8'h07); stream.push_back(8'hFF); stream.push_back(8'hFF);
    stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h01);
    stream.push_back(8'h06);
    model();
    check("model_xor", 32'(m_xor), 32'h06);
    check("model_w0", 32'(exp_q[0].d), 32'h7FFFF);
    check("model_w1", 32'(exp_q[1].d), 32'h00001);
    check("model_good", 32'(m_good), 32'd1);
    do_start();
    send(0, -1, -1);
    check("mem0", 32'(mem[0]), 32'h7FFFF);
    check("mem1", 32'(mem[1]), 32'h00001);

    // Same image, checksum flipped: writes still happen, session errors.
    stream[8] = 8'h07;
    model();
    check("model_bad", 32'(m_good), 32'd0);
    do_start();
    send(0, -1, -1);

    // Zero and oversize lengths.
    make_stream(0, 1'b0, 8'h00);
    model();
    do_start();
    send(0, -1, -1);
    stream.delete();
    stream.push_back(8'h10); stream.push_back(8'h01);
    model();
    do_start();
    send(0, -1, -1);

    // Random valid gaps, plus an ignored start pulse mid-session.
    make_stream(5, 1'b1, 8'h00);
    model();
    do_start();
    send(40, -1, 5);

    // Reset while in B1 of the fourth word, then a fresh full load.
    make_stream(4, 1'b1, 8'h00);
    model();
    do_start();
    send(20, 12, -1);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    model();
    do_start();
    send(20, -1, -1);

    // Restart straight after DONE, then full-depth image.
    make_stream(4096, 1'b0, 8'h00);
    model();
    do_start();
    send(0, -1, -1);
    check("mem_last", 32'(mem[4095]), 32'(19'(4095 * 37 + 5)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
